mux_rr_arbiter: RTL
===================

Name: mux_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares one 2:1 data mux and its single output channel between two streaming sources.
- Grants are held per burst and terminate on `last` or after a maximum beat count, so neither source can starve the other.
- Drives the mux select and gates valid/ready handshakes.
- Sits directly in front of the shared 2:1 mux datapath.

Parameters:
- DATA_W, 8, width of each data path through the mux.
- MAX_HOLD, 4, maximum beats per grant before a forced release. Must be ≥1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a beat.
- req0_data  input  DATA_W  requester 0 payload.
- req0_last  input  1  final beat of the requester 0 burst.
- req0_ready  output  1  beat from requester 0 accepted this cycle.
- req1_valid  input  1  requester 1 has a beat.
- req1_data  input  DATA_W  requester 1 payload.
- req1_last  input  1  final beat of the requester 1 burst.
- req1_ready  output  1  beat from requester 1 accepted this cycle.
- out_valid  output  1  muxed beat valid.
- out_data  output  DATA_W  muxed payload.
- out_last  output  1  muxed last flag.
- out_ready  input  1  downstream accepts the beat.
- sel  output  1  mux select: 0 = req0, 1 = req1. Registered.
- busy  output  1  high while any grant is active.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, sel=0, busy=0, beat count=0.
  - Priority pointer favours req0.
  - out_valid=0, req0_ready=0, req1_ready=0.
- Datapath is combinational from the registered sel:
  - out_data = sel ? req1_data : req0_data.
  - out_last = sel ? req1_last : req0_last.
- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - out_valid=0, both ready=0, sel holds its previous value.
  - If exactly one valid is high, that requester is granted on the next edge.
  - If both are high, the requester named by the pointer wins.
  - Grant latency: 1 cycle from valid to sel/busy update. First transfer possible in the cycle after the grant.
- GRANTx:
  - busy=1, sel=x, out_valid=reqx_valid, reqx_ready=out_ready. The other requester's ready=0.
  - Handshake = out_valid && out_ready. Each handshake increments the beat count.
- Release occurs on the edge where a handshake has out_last=1 or the count reaches MAX_HOLD. On release:
  - The pointer is set to favour the other requester.
  - The count clears.
  - Next state is GRANT(other) if the other requester's valid is high in that cycle (no idle bubble).
  - Otherwise GRANTx again if reqx_valid is high (new burst, count restarts).
  - Otherwise IDLE.
- No release without a handshake. reqx_valid dropping mid-burst keeps the grant; out_valid simply goes low.
- Count width is clog2(MAX_HOLD+1). Count never exceeds MAX_HOLD and never wraps.
- MAX_HOLD=1: the grant alternates every beat when both requesters are valid.
- Reset mid-burst: IDLE at the next edge, sel=0, readies low, pointer back to req0. Partial bursts are abandoned and not tracked.
- No combinational path from out_ready to any valid output.

Test Plan:
1. rst=1 for 2 cycles -> sel=0, busy=0, out_valid=0, both readies 0. Then req1_valid=1, data=0x5A, last=1, out_ready=1 -> sel=1 after 1 cycle. out_data=0x5A and req1_ready=1 for one cycle, then IDLE.
2. Both valid from IDLE, 2-beat bursts (last on 2nd), out_ready=1 -> order is req0 beats 1-2, then req1 beats 1-2 with no idle cycle between. sel sequence 0,0,1,1.
3. req0 continuously valid, last never set, MAX_HOLD=4, req1 valid -> req0 gets exactly 4 handshakes, then sel=1 on the next edge.
4. GRANT0 with out_ready toggling 1,0,1,0 -> req0_ready mirrors out_ready. Beat count advances only on the 2 handshakes, and the grant is held.
5. rst asserted mid-burst in GRANT1 after 2 beats -> next cycle state IDLE, sel=0, req1_ready=0. After release of rst with both valid, req0 is granted first.
6. Only req0 valid, repeated 1-beat bursts -> back-to-back GRANT0 with no IDLE gap and sel stays 0. req1 then asserts -> granted at the next release.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Two-requester round-robin burst arbiter driving the select of
//               a shared 2:1 data mux and gating the valid/ready handshakes.
//               A grant is held for a burst and released on a last beat or
//               after MAX_HOLD beats, then priority passes to the other side.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              sel,
    output logic              busy
);

    localparam int c_cnt_w = $clog2(MAX_HOLD + 1);
    // Count value at which the next handshake is the final one of the grant.
    localparam logic [c_cnt_w-1:0] c_max_m1 = c_cnt_w'(MAX_HOLD - 1);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_ptr;      // 0 = req0 wins a tie, 1 = req1 wins
    logic [c_cnt_w-1:0]   r_count;
    logic                 w_hs;
    logic                 w_release;

    // Data path follows the registered select only.
    assign out_data = sel ? req1_data : req0_data;
    assign out_last = sel ? req1_last : req0_last;
    assign busy     = (r_state != IDLE);

    // Handshake gating: valid comes only from the granted requester; ready
    // is passed straight through to it (no path from out_ready to out_valid).
    always_comb begin
        out_valid  = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (r_state)
            GRANT0: begin
                out_valid  = req0_valid;
                req0_ready = out_ready;
            end
            GRANT1: begin
                out_valid  = req1_valid;
                req1_ready = out_ready;
            end
            default: begin
                out_valid  = 1'b0;
            end
        endcase
    end

    assign w_hs      = out_valid & out_ready;
    assign w_release = w_hs & (out_last | (r_count == c_max_m1));

    // Grant state machine, round-robin pointer, beat counter and mux select.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            sel     <= 1'b0;
            r_ptr   <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_count <= '0;
                    if (req0_valid && (!req1_valid || !r_ptr)) begin
                        r_state <= GRANT0;
                        sel     <= 1'b0;
                    end else if (req1_valid) begin
                        r_state <= GRANT1;
                        sel     <= 1'b1;
                    end
                end
                GRANT0: begin
                    if (w_release) begin
                        r_ptr   <= 1'b1;
                        r_count <= '0;
                        if (req1_valid) begin
                            r_state <= GRANT1;
                            sel     <= 1'b1;
                        end else if (req0_valid) begin
                            r_state <= GRANT0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_hs) begin
                        r_count <= r_count + c_one;
                    end
                end
                GRANT1: begin
                    if (w_release) begin
                        r_ptr   <= 1'b0;
                        r_count <= '0;
                        if (req0_valid) begin
                            r_state <= GRANT0;
                            sel     <= 1'b0;
                        end else if (req1_valid) begin
                            r_state <= GRANT1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_hs) begin
                        r_count <= r_count + c_one;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
